// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: groups the run control, decode inputs, memory handshake
// and phase-gated write enables of the SIMPLE core's phase sequencer.
// master = the sequencer itself, slave = the surrounding core/datapath.
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    // Run control and decode from the controller
    logic             exec;
    logic             is_mem;
    logic             reg_write;
    logic             mem_write;
    logic             halt;
    logic             mem_ready;

    // Phase and gated enables back to the datapath
    logic [4:0]       phase;
    logic             ir_we;
    logic             pc_we;
    logic             rf_we;
    logic             dm_we;
    logic             dm_req;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  exec, is_mem, reg_write, mem_write, halt, mem_ready,
        output phase, ir_we, pc_we, rf_we, dm_we, dm_req, running, halted, retired
    );

    modport slave (
        output exec, is_mem, reg_write, mem_write, halt, mem_ready,
        input  phase, ir_we, pc_we, rf_we, dm_we, dm_req, running, halted, retired
    );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-cycle IF/ID/EX/MEM/WB sequencer for the SIMPLE core.
// Gates IR/PC/register-file/data-memory writes by phase, handles run/halt and
// data-memory wait states, and counts retired instructions.
// Optional feature macro: PHASE_SKIP_EN -- when defined, non-memory
// instructions go EX -> WB directly; otherwise every instruction visits MEM.
module phase_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    phase_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             mem_acc_reg;   // is_mem captured in EX: real LD/ST in MEM
    logic [4:0]       phase_reg;
    logic             ir_we_reg;
    logic             pc_we_reg;
    logic             dm_req_reg;
    logic             running_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             mem_acc_next;

    // One-hot phase code for a state; IDLE and HALT show no phase.
    function automatic logic [4:0] phase_onehot(input state_t s);
        case (s)
            S_IF:    phase_onehot = 5'b00001;
            S_ID:    phase_onehot = 5'b00010;
            S_EX:    phase_onehot = 5'b00100;
            S_MEM:   phase_onehot = 5'b01000;
            S_WB:    phase_onehot = 5'b10000;
            default: phase_onehot = 5'b00000;
        endcase
    endfunction

    // Next-state rules; decode inputs only matter from EX onwards.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.exec) state_next = S_IF;
            S_HALT:  if (bus.exec) state_next = S_IF;
            S_IF:    state_next = S_ID;
            S_ID:    state_next = S_EX;
`ifdef PHASE_SKIP_EN
            S_EX:    state_next = bus.is_mem ? S_MEM : S_WB;
`else
            S_EX:    state_next = S_MEM;
`endif
            // Non-memory visits to MEM ignore mem_ready and last one cycle.
            S_MEM:   if (!mem_acc_reg || bus.mem_ready) state_next = S_WB;
            S_WB:    state_next = bus.halt ? S_HALT : S_IF;
            default: state_next = S_IDLE;
        endcase
    end

    // A memory request is live in MEM only for a decoded LD/ST.
    always_comb begin
        mem_acc_next = (state_reg == S_EX) ? bus.is_mem : mem_acc_reg;
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            mem_acc_reg <= 1'b0;
            phase_reg   <= 5'b00000;
            ir_we_reg   <= 1'b0;
            pc_we_reg   <= 1'b0;
            dm_req_reg  <= 1'b0;
            running_reg <= 1'b0;
            halted_reg  <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mem_acc_reg <= mem_acc_next;
            phase_reg   <= phase_onehot(state_next);
            ir_we_reg   <= (state_next == S_IF);
            pc_we_reg   <= (state_next == S_WB);
            dm_req_reg  <= (state_next == S_MEM) && mem_acc_next;
            running_reg <= (state_next != S_IDLE) && (state_next != S_HALT);
            halted_reg  <= (state_next == S_HALT);
            // Every WB retires an instruction, HLT included; wraps naturally.
            if (state_reg == S_WB) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    assign bus.phase   = phase_reg;
    assign bus.ir_we   = ir_we_reg;
    assign bus.pc_we   = pc_we_reg;
    assign bus.rf_we   = pc_we_reg & bus.reg_write;
    assign bus.dm_req  = dm_req_reg;
    assign bus.dm_we   = dm_req_reg & bus.mem_write;
    assign bus.running = running_reg;
    assign bus.halted  = halted_reg;
    assign bus.retired = retired_reg;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scenarios followed by randomized run/decode/
// memory-ready stimulus, all checked each cycle against a behavioural model.
module tb_phase_sequencer;
    localparam int CNT_W = 4;   // small counter so wrap-around is reachable
`ifdef PHASE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    phase_sequencer_if #(.CNT_W(CNT_W)) bus();

    phase_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 executing an instruction, 2 halted.
    // k counts cycles into the instruction (0 IF, 1 ID, 2 EX, 3 = after EX).
    int       m_mode = 0;
    int       m_k = 0;
    bit       m_memv = 0;   // instruction spends time in MEM
    bit       m_acc = 0;    // that MEM time is a real LD/ST access
    bit       m_memd = 0;   // MEM portion finished
    int       m_ret = 0;

    function automatic int cur_idx();
        if (m_k < 3) return m_k;
        if (m_memv && !m_memd) return 3;
        return 4;
    endfunction

    // Compare every cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        int idx;
        logic [4:0] e_phase;
        idx = (m_mode == 1) ? cur_idx() : -1;
        e_phase = (idx >= 0) ? 5'(1 << idx) : 5'b0;
        chk("phase",   bus.phase,   e_phase);
        chk("ir_we",   bus.ir_we,   idx == 0);
        chk("pc_we",   bus.pc_we,   idx == 4);
        chk("rf_we",   bus.rf_we,   (idx == 4) && bus.reg_write);
        chk("dm_req",  bus.dm_req,  (idx == 3) && m_acc);
        chk("dm_we",   bus.dm_we,   (idx == 3) && m_acc && bus.mem_write);
        chk("running", bus.running, m_mode == 1);
        chk("halted",  bus.halted,  m_mode == 2);
        chk("retired", bus.retired, m_ret);

        if (reset) begin
            m_mode = 0; m_k = 0; m_ret = 0; m_memd = 0; m_memv = 0; m_acc = 0;
        end else if (m_mode != 1) begin
            if (bus.exec) begin m_mode = 1; m_k = 0; end
        end else begin
            if (idx < 2) m_k++;
            else if (idx == 2) begin
                m_memv = bus.is_mem || !SKIP;
                m_acc  = bus.is_mem;
                m_memd = 0;
                m_k++;
            end else if (idx == 3) begin
                if (!m_acc || bus.mem_ready) m_memd = 1;
            end else begin
                m_ret = (m_ret + 1) % (1 << CNT_W);
                if (bus.halt) m_mode = 2;
                else m_k = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 NOP, 1 ADD, 2 LD, 3 ST, 4 HLT
    task automatic set_instr(input int kind);
        bus.is_mem    = (kind == 2) || (kind == 3);
        bus.reg_write = (kind == 1) || (kind == 2);
        bus.mem_write = (kind == 3);
        bus.halt      = (kind == 4);
    endtask

    initial begin
        int n;
        int w;
        int cnt;
        bit saw_pc;

        bus.exec = 0; bus.mem_ready = 0;
        set_instr(0);
        reset = 1;
        tick(); tick();
        reset = 0;

        // Idle with exec low.
        for (int i = 0; i < 10; i++) tick();
        chk("idle_phase", bus.phase, 5'b0);
        chk("idle_retired", bus.retired, 0);

        // ADD from an exec pulse.
        set_instr(1);
        bus.exec = 1;
        tick();
        bus.exec = 0;
        chk("add_start_if", bus.phase, 5'b00001);
        n = 0;
        do begin tick(); n++; end while (bus.phase != 5'b00001 && n < 20);
        chk("add_len", n, SKIP ? 4 : 5);
        chk("add_retired", bus.retired, 1);

        // ST with three wait states.
        set_instr(3);
        bus.mem_ready = 0;
        w = 0; n = 0;
        do begin
            tick(); n++;
            if (bus.phase == 5'b01000) begin
                w++;
                bus.mem_ready = (w >= 4);
            end
        end while (bus.phase != 5'b00001 && n < 30);
        chk("st_len", n, 8);
        chk("st_mem_cycles", w, 4);
        chk("st_retired", bus.retired, 2);

        // HLT, then resume after some idle cycles.
        set_instr(4);
        bus.mem_ready = 0;
        n = 0; saw_pc = 0;
        do begin
            tick(); n++;
            if (bus.phase == 5'b10000 && bus.pc_we) saw_pc = 1;
        end while (!bus.halted && n < 20);
        chk("hlt_len", n, SKIP ? 4 : 5);
        chk("hlt_pc_we", saw_pc, 1);
        chk("hlt_phase", bus.phase, 5'b0);
        chk("hlt_retired", bus.retired, 3);
        for (int i = 0; i < 5; i++) tick();
        chk("hlt_stays", bus.halted, 1);
        bus.exec = 1;
        tick();
        bus.exec = 0;
        chk("resume_if", bus.phase, 5'b00001);

        // Reset during a MEM wait state.
        set_instr(2);
        bus.mem_ready = 0;
        n = 0;
        do begin tick(); n++; end while (bus.phase != 5'b01000 && n < 20);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_phase", bus.phase, 5'b0);
        chk("rst_dm_we", bus.dm_we, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_retired", bus.retired, 0);

        // Counter wrap after 2^CNT_W retirements.
        set_instr(0);
        bus.exec = 1;
        tick();
        bus.exec = 0;
        cnt = 0; n = 0;
        while (cnt < 16 && n < 200) begin
            if (bus.pc_we) cnt++;
            tick(); n++;
        end
        chk("wrap_count", cnt, 16);
        chk("wrap_retired", bus.retired, 0);

        // Randomized run: exec toggles freely, decode is fixed per instruction.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.exec = (m_mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            bus.mem_ready = ($urandom_range(0, 9) < 4);
            if (m_mode != 1) begin
                bus.is_mem    = 1'($urandom_range(0, 1));
                bus.reg_write = 1'($urandom_range(0, 1));
                bus.mem_write = 1'($urandom_range(0, 1));
                bus.halt      = 1'($urandom_range(0, 1));
            end else if (m_k == 0) begin
                set_instr((c % 7 == 0) ? 4 : int'($urandom_range(0, 3)));
            end
            tick();
        end

        reset = 1;
        tick(); tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
